reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 94 +++++++++
 tb/tb_reg_file_mp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Two-write-port, multi-read-port register file with byte
//               strobes, optional zero register, write-to-read forwarding
//               and optional registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_READ     = 2,
    parameter int ZERO_REG     = 1,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     wen,
    input  logic [2*ADDR_WIDTH-1:0]        waddr,
    input  logic [2*DATA_WIDTH-1:0]        wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0]    wstrb,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata
);

    localparam int c_depth  = 2 ** ADDR_WIDTH;
    localparam int c_nbytes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem  [c_depth];
    logic [DATA_WIDTH-1:0] w_next [c_depth];

    // Port 1 is applied after port 0 so it wins any byte both ports strobe.
    always_comb begin
        for (int e = 0; e < c_depth; e++) begin
            w_next[e] = r_mem[e];
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < c_nbytes; b++) begin
                    if (wen[p] && (waddr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e))
                        && wstrb[p*c_nbytes + b]) begin
                        w_next[e][b*8 +: 8] = wdata[p*DATA_WIDTH + b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < c_depth; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < c_depth; e++) begin
                if ((ZERO_REG == 0) || (e != 0)) begin
                    r_mem[e] <= w_next[e];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_rd;

        assign w_addr = raddr[r*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_rd = (BYPASS != 0) ? w_next[w_addr] : r_mem[w_addr];
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_rd = '0;
            end
        end

        if (READ_LATENCY == 0) begin : g_comb
            // Forwarded write data must not leak out while reset is held.
            assign rdata[r*DATA_WIDTH +: DATA_WIDTH] = rst ? w_rd : '0;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_rd;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rd <= '0;
                end else begin
                    r_rd <= w_rd;
                end
            end

            assign rdata[r*DATA_WIDTH +: DATA_WIDTH] = r_rd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Random and directed bench for reg_file_mp (default build plus
//               a ZERO_REG=0 / BYPASS=0 / READ_LATENCY=1 build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wen = '0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata_d;
    logic [63:0] rdata_a;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [31:0] m_def [32];
    logic [31:0] m_alt [32];
    logic [31:0] exp_alt [2];

    always #5 clk = ~clk;

    reg_file_mp u_dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (raddr),
        .rdata (rdata_d)
    );

    reg_file_mp #(
        .ZERO_REG     (0),
        .BYPASS       (0),
        .READ_LATENCY (1)
    ) u_alt (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (raddr),
        .rdata (rdata_a)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Entry contents after this cycle's writes: port 1 bytes first, else port 0.
    function automatic logic [31:0] merged(input logic [31:0] old, input logic [4:0] a);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) begin
            if (wen[1] && waddr[9:5] == a && wstrb[4+b])
                v[b*8 +: 8] = wdata[32 + b*8 +: 8];
            else if (wen[0] && waddr[4:0] == a && wstrb[b])
                v[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_def(input logic [4:0] a);
        if (!rst || a == 5'd0) return 32'h0;
        return merged(m_def[a], a);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < 32; a++) begin
                m_def[a] <= '0;
                m_alt[a] <= '0;
            end
            exp_alt[0] <= '0;
            exp_alt[1] <= '0;
        end else begin
            exp_alt[0] <= m_alt[raddr[4:0]];
            exp_alt[1] <= m_alt[raddr[9:5]];
            for (int a = 0; a < 32; a++) begin
                if (a != 0) m_def[a] <= merged(m_def[a], 5'(a));
                m_alt[a] <= merged(m_alt[a], 5'(a));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int r = 0; r < 2; r++) begin
                check($sformatf("dut_rd%0d", r), rdata_d[r*32 +: 32], exp_def(raddr[r*5 +: 5]));
                check($sformatf("alt_rd%0d", r), rdata_a[r*32 +: 32], exp_alt[r]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [1:0] e, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [3:0] s0, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [3:0] s1);
        wen   = e;
        waddr = {a1, a0};
        wdata = {d1, d0};
        wstrb = {s1, s0};
    endtask

    task automatic rand_drive();
        wen        = 2'($urandom_range(0, 3));
        waddr[4:0] = 5'($urandom_range(0, 31));
        waddr[9:5] = ($urandom_range(0, 3) == 0) ? waddr[4:0] : 5'($urandom_range(0, 31));
        wdata      = {$urandom(), $urandom()};
        wstrb[3:0] = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        wstrb[7:4] = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        raddr[4:0] = ($urandom_range(0, 1) == 0) ? waddr[4:0] : 5'($urandom_range(0, 31));
        raddr[9:5] = ($urandom_range(0, 1) == 0) ? waddr[9:5] : 5'($urandom_range(0, 31));
    endtask

    task automatic read_all_zero(input string tag);
        wen = '0;
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            @(negedge clk);
            check({tag, "_p0"}, rdata_d[31:0], 32'h0);
            check({tag, "_p1"}, rdata_d[63:32], 32'h0);
            next_cycle();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Write attempted while reset is held must not show or land.
        set_wr(2'b11, 5'd5, 32'hFFFFFFFF, 4'hF, 5'd6, 32'hFFFFFFFF, 4'hF);
        raddr = {5'd6, 5'd5};
        @(negedge clk);
        check("in_rst_rd", rdata_d[31:0], 32'h0);
        next_cycle();
        rst = 1'b1;
        read_all_zero("post_rst");

        // Dual write to one address with overlapping strobes.
        set_wr(2'b11, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 32'h11223344, 4'h3);
        raddr = {5'd5, 5'd5};
        @(negedge clk);
        check("byp_merge", rdata_d[31:0], 32'hDEAD3344);
        next_cycle();
        wen = '0;
        @(negedge clk);
        check("stored_merge", rdata_d[63:32], 32'hDEAD3344);
        check("alt_old", rdata_a[31:0], 32'h0);
        next_cycle();
        @(negedge clk);
        check("alt_new", rdata_a[31:0], 32'hDEAD3344);
        next_cycle();

        // Entry 0 handling.
        set_wr(2'b01, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 32'h0, 4'h0);
        raddr = '0;
        @(negedge clk);
        check("zero_byp", rdata_d[31:0], 32'h0);
        next_cycle();
        wen = '0;
        @(negedge clk);
        check("zero_stored", rdata_d[31:0], 32'h0);
        check("alt_r0_old", rdata_a[31:0], 32'h0);
        next_cycle();
        @(negedge clk);
        check("alt_r0_new", rdata_a[31:0], 32'hFFFFFFFF);
        next_cycle();

        // Registered read without forwarding: two-cycle visibility.
        set_wr(2'b01, 5'd7, 32'hA5A5A5A5, 4'hF, 5'd0, 32'h0, 4'h0);
        raddr = {5'd7, 5'd0};
        next_cycle();
        wen = '0;
        @(negedge clk);
        check("alt_r7_old", rdata_a[63:32], 32'h0);
        next_cycle();
        @(negedge clk);
        check("alt_r7_new", rdata_a[63:32], 32'hA5A5A5A5);
        check("dut_r7", rdata_d[63:32], 32'hA5A5A5A5);
        next_cycle();

        // Partial strobe, then enabled write with no strobes.
        set_wr(2'b01, 5'd9, 32'h12345678, 4'hF, 5'd0, 32'h0, 4'h0);
        raddr = {5'd9, 5'd9};
        next_cycle();
        set_wr(2'b01, 5'd9, 32'hFFFFFFFF, 4'h4, 5'd0, 32'h0, 4'h0);
        @(negedge clk);
        check("strb4_byp", rdata_d[31:0], 32'h12FF5678);
        next_cycle();
        set_wr(2'b11, 5'd9, 32'h0, 4'h0, 5'd9, 32'h0, 4'h0);
        @(negedge clk);
        check("strb0_byp", rdata_d[31:0], 32'h12FF5678);
        next_cycle();
        wen = '0;
        @(negedge clk);
        check("strb0_stored", rdata_d[63:32], 32'h12FF5678);
        next_cycle();

        for (int i = 0; i < 4800; i++) begin
            rand_drive();
            next_cycle();
        end

        // Asynchronous reset mid-cycle while a write is active.
        set_wr(2'b11, 5'd3, 32'hCAFEF00D, 4'hF, 5'd4, 32'hBEEFCAFE, 4'hF);
        raddr = {5'd4, 5'd3};
        rst = 1'b0;
        #1;
        check("async_rst_p0", rdata_d[31:0], 32'h0);
        check("async_rst_alt", rdata_a[31:0], 32'h0);
        next_cycle();
        rand_drive();
        next_cycle();
        rst = 1'b1;
        read_all_zero("mid_rst");

        for (int i = 0; i < 4800; i++) begin
            rand_drive();
            next_cycle();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
